// File: rtl/alu_pkg.sv
// Shared ALU control encodings and multiply-sequencer state codes.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_SRA = 4'd8;
   localparam logic [3:0] ALU_LUI = 4'd9;
   localparam logic [3:0] ALU_BLE = 4'd11;
   localparam logic [3:0] ALU_NOR = 4'd12;

   localparam logic [2:0] MS_IDLE   = 3'd0;
   localparam logic [2:0] MS_ABS_A  = 3'd1;
   localparam logic [2:0] MS_ABS_B  = 3'd2;
   localparam logic [2:0] MS_ITER   = 3'd3;
   localparam logic [2:0] MS_FIX_LO = 3'd4;
   localparam logic [2:0] MS_FIX_HI = 3'd5;
   localparam logic [2:0] MS_DONE   = 3'd6;

endpackage

// File: rtl/alu_mult_seq.sv
// Shift-add 32x32->64 multiplier that borrows the shared ALU one granted cycle at a time.
// Signed operation is built only when ALU_MULT_SIGNED_EN is defined.
module alu_mult_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             alu_req_o,
   input  logic             alu_gnt_i,
   output logic [WIDTH-1:0] alu_src1_o,
   output logic [WIDTH-1:0] alu_src2_o,
   output logic [3:0]       alu_ctrl_o,
   input  logic [WIDTH-1:0] alu_result_i
);

   logic [2:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             last_iter;
   logic [WIDTH-1:0] iter_hi;
   logic [WIDTH-1:0] iter_lo;
`ifdef ALU_MULT_SIGNED_EN
   logic             sgn;
   logic             neg_flag;
   logic             lo_zero;
   logic [WIDTH-1:0] fix_hi;
`else
   logic             unused_signed;
   assign unused_signed = signed_i;
`endif

   assign busy_o    = (state != MS_IDLE);
   assign done_o    = (state == MS_DONE);
   assign alu_req_o = busy_o && (state != MS_DONE);

   always_comb begin
      alu_src1_o = '0;
      alu_src2_o = '0;
      alu_ctrl_o = '0;
      case (state)
         MS_ITER: begin
            alu_src1_o = p_hi;
            alu_src2_o = p_lo[0] ? mcand : '0;
            alu_ctrl_o = ALU_ADD;
         end
`ifdef ALU_MULT_SIGNED_EN
         MS_ABS_A: begin
            alu_src2_o = mcand;
            alu_ctrl_o = ALU_SUB;
         end
         MS_ABS_B, MS_FIX_LO: begin
            alu_src2_o = p_lo;
            alu_ctrl_o = ALU_SUB;
         end
         MS_FIX_HI: begin
            alu_src1_o = ~p_hi;
            alu_src2_o = {{(WIDTH-1){1'b0}}, lo_zero};
            alu_ctrl_o = ALU_ADD;
         end
`endif
         default: ;
      endcase
   end

   // The ALU drops the adder carry-out; recover it from unsigned wrap-around.
   assign carry     = (alu_result_i < p_hi);
   assign iter_hi   = {carry, alu_result_i[WIDTH-1:1]};
   assign iter_lo   = {alu_result_i[0], p_lo[WIDTH-1:1]};
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`ifdef ALU_MULT_SIGNED_EN
   assign fix_hi    = neg_flag ? alu_result_i : p_hi;
`endif

   // During ABS_A/ABS_B, mcand and p_lo still hold the raw operands awaiting negation.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= MS_IDLE;
         mcand    <= '0;
         p_hi     <= '0;
         p_lo     <= '0;
         cnt      <= '0;
         hi_o     <= '0;
         lo_o     <= '0;
`ifdef ALU_MULT_SIGNED_EN
         sgn      <= 1'b0;
         neg_flag <= 1'b0;
         lo_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            MS_IDLE: if (start_i) begin
               mcand <= src_a_i;
               p_lo  <= src_b_i;
               p_hi  <= '0;
               cnt   <= '0;
`ifdef ALU_MULT_SIGNED_EN
               sgn      <= signed_i;
               neg_flag <= signed_i & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
               lo_zero  <= 1'b0;
               state    <= signed_i ? MS_ABS_A : MS_ITER;
`else
               state <= MS_ITER;
`endif
            end
`ifdef ALU_MULT_SIGNED_EN
            MS_ABS_A: if (alu_gnt_i) begin
               if (mcand[WIDTH-1]) mcand <= alu_result_i;
               state <= MS_ABS_B;
            end
            MS_ABS_B: if (alu_gnt_i) begin
               if (p_lo[WIDTH-1]) p_lo <= alu_result_i;
               state <= MS_ITER;
            end
            MS_FIX_LO: if (alu_gnt_i) begin
               lo_zero <= (p_lo == '0);
               if (neg_flag) p_lo <= alu_result_i;
               state <= MS_FIX_HI;
            end
            MS_FIX_HI: if (alu_gnt_i) begin
               p_hi  <= fix_hi;
               hi_o  <= fix_hi;
               lo_o  <= p_lo;
               state <= MS_DONE;
            end
`endif
            MS_ITER: if (alu_gnt_i) begin
               p_hi <= iter_hi;
               p_lo <= iter_lo;
               cnt  <= cnt + CNT_W'(1);
               if (last_iter) begin
`ifdef ALU_MULT_SIGNED_EN
                  if (sgn) begin
                     state <= MS_FIX_LO;
                  end else begin
                     hi_o  <= iter_hi;
                     lo_o  <= iter_lo;
                     state <= MS_DONE;
                  end
`else
                  hi_o  <= iter_hi;
                  lo_o  <= iter_lo;
                  state <= MS_DONE;
`endif
               end
            end
            MS_DONE: state <= MS_IDLE;
            default: state <= MS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: directed table, multi-cycle corner sequences, random ops.
module tb_alu_mult_seq;
   import alu_pkg::*;

`ifdef ALU_MULT_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        busy, done, req;
   logic        gnt = 1'b1;
   logic [31:0] hi, lo, src1, src2, result;
   logic [3:0]  ctrl;

   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   int unsigned stall_from = 0;
   int unsigned stall_to = 0;
   int unsigned inj_k = 0;
   bit          rand_gnt = 1'b0;
   bit          held_bad = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      case (ctrl)
         ALU_ADD: result = src1 + src2;
         ALU_SUB: result = src1 - src2;
         default: result = '0;
      endcase
   end

   alu_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .signed_i(sgn),
      .src_a_i(src_a), .src_b_i(src_b), .busy_o(busy), .done_o(done),
      .hi_o(hi), .lo_o(lo), .alu_req_o(req), .alu_gnt_i(gnt),
      .alu_src1_o(src1), .alu_src2_o(src2), .alu_ctrl_o(ctrl),
      .alu_result_i(result)
   );

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint      sa, sb;
      logic [63:0] ua, ub;
      if (s && SIGNED_EN) begin
         sa = $signed(a);
         sb = $signed(b);
         return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      int unsigned w = 0;
      @(posedge clk); #1;
      while (busy && w < 60) begin
         @(posedge clk); #1;
         w++;
      end
      check("issue_idle", 64'(busy), 64'(0));
      src_a = a;
      src_b = b;
      sgn   = s;
      start = 1'b1;
      @(negedge clk);
      check("idle_req", 64'(req), 64'(0));
      check("idle_alu_outs", 64'(src1 | src2 | {28'b0, ctrl}), 64'(0));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] prod, output int unsigned lat,
                         output int unsigned granted, output int unsigned addc);
      int unsigned k = 1;
      bit          got = 1'b0;
      logic [31:0] c1 = '0, c2 = '0;
      issue(a, b, s);
      granted = 0;
      addc    = 0;
      lat     = 0;
      while (k <= 300) begin
         gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : !(k >= stall_from && k < stall_to);
         if (k == inj_k) begin
            start = 1'b1;
            src_a = 32'd100;
            src_b = 32'd100;
         end
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat = k;
            break;
         end
         if (gnt) begin
            granted++;
            if (req && ctrl == ALU_ADD) addc++;
         end
         if (k == stall_from) begin
            c1 = src1;
            c2 = src2;
         end else if (k > stall_from && k <= stall_to && (src1 !== c1 || src2 !== c2)) begin
            held_bad = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         k++;
      end
      gnt = 1'b1;
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL op_timeout: no done_o within 300 cycles");
      end
      prod = {hi, lo};
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[$];
      logic [63:0] prod;
      int unsigned lat, granted, addc;

      vecs.push_back('{32'd7,         32'd6,         1'b0, 32'h0,        32'h2A,       33});
      vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'hFFFFFFFE, 32'h00000001, 33});
      vecs.push_back('{32'd0,         32'h12345678,  1'b0, 32'h0,        32'h0,        33});
      vecs.push_back('{32'h80000000,  32'd2,         1'b0, 32'h1,        32'h0,        33});
`ifdef ALU_MULT_SIGNED_EN
      vecs.push_back('{32'hFFFFFFFD,  32'd5,         1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 37});
      vecs.push_back('{32'hFFFFFFFC,  32'hFFFFFFFC,  1'b1, 32'h0,        32'h10,       37});
      vecs.push_back('{32'h80000000,  32'h80000000,  1'b1, 32'h40000000, 32'h0,        37});
      vecs.push_back('{32'h7FFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF, 32'h80000001, 37});
      vecs.push_back('{32'd0,         32'hFFFFFFFF,  1'b1, 32'h0,        32'h0,        37});
`else
      vecs.push_back('{32'hFFFFFFFD,  32'd5,         1'b1, 32'h4,        32'hFFFFFFF1, 33});
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_req", 64'(req), 64'(0));
      check("rst_hilo", {hi, lo}, 64'(0));
      check("rst_alu_outs", 64'(src1 | src2 | {28'b0, ctrl}), 64'(0));
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, prod, lat, granted, addc);
         check($sformatf("vec%0d_product", i), prod, {vecs[i].hi, vecs[i].lo});
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("vec%0d_add_cycles", i), 64'(addc),
               64'((vecs[i].s && SIGNED_EN) ? 33 : 32));
      end

      // Five ungranted cycles in the middle of ITER.
      stall_from = 10;
      stall_to   = 15;
      held_bad   = 1'b0;
      run_op(32'd7, 32'd6, 1'b0, prod, lat, granted, addc);
      check("stall_product", prod, 64'h2A);
      check("stall_latency", 64'(lat), 64'(38));
      check("stall_held", 64'(held_bad), 64'(0));
      stall_from = 0;
      stall_to   = 0;

      // Start pulsed while busy must not disturb the running operation.
      inj_k = 10;
      run_op(32'd7, 32'd6, 1'b0, prod, lat, granted, addc);
      inj_k = 0;
      check("busy_start_product", prod, 64'h2A);
      check("busy_start_latency", 64'(lat), 64'(33));

      // Start raised during the DONE cycle is dropped.
      run_op(32'd3, 32'd4, 1'b0, prod, lat, granted, addc);
      check("pre_done_start_product", prod, 64'd12);
      start = 1'b1;
      src_a = 32'd5;
      src_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("done_start_ignored", 64'(busy), 64'(0));
      check("done_pulse_width", 64'(done), 64'(0));
      check("hilo_hold", {hi, lo}, 64'd12);

      // Asynchronous reset mid-operation.
      issue(32'd123, 32'd456, 1'b0);
      repeat (14) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_req", 64'(req), 64'(0));
      check("midrst_hilo", {hi, lo}, 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd9, 32'd9, 1'b0, prod, lat, granted, addc);
      check("after_rst_product", prod, 64'd81);
      check("after_rst_latency", 64'(lat), 64'(33));

      rand_gnt = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
         rs = 1'($urandom_range(0, 1));
         run_op(ra, rb, rs, prod, lat, granted, addc);
         check($sformatf("rand%0d_product", i), prod, ref_mul(ra, rb, rs));
         check($sformatf("rand%0d_granted", i), 64'(granted),
               64'((rs && SIGNED_EN) ? 36 : 32));
      end
      rand_gnt = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
